// File: rtl/irq_trap_ctrl.sv
// Trap controller: prioritises synchronous exceptions over enabled interrupts and hands one trap at a time to the pipeline.
// Optional macro IRQ_TRAP_CTRL_EDGE_EN selects edge-triggered interrupt pending; default build is level-triggered.
module irq_trap_ctrl #(
  parameter int NUM_IRQ        = 8,
  parameter int NUM_EXC        = 4,
  parameter int IRQ_CAUSE_BASE = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EXC-1:0] exc_vec,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_en_wdata,
  input  logic               irq_en_we,
  input  logic               global_ie,
  input  logic               trap_ack,
  input  logic               trap_return,
  output logic               trap_req,
  output logic [31:0]        trap_cause,
  output logic               trap_is_irq,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic               busy,
  output logic               double_fault
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             r_state, w_state_nxt;
  logic [31:0]        r_cause, w_cause_nxt;
  logic               r_is_irq, w_is_irq_nxt;
  logic               r_dfault, w_dfault_nxt;
  logic [NUM_IRQ-1:0] r_pending, w_pending_nxt;
  logic [NUM_IRQ-1:0] r_enable;
  logic [NUM_IRQ-1:0] w_irq_act;
  logic               w_exc_any, w_irq_go;
  logic [4:0]         w_exc_idx, w_irq_idx;

  function automatic logic [4:0] lowest_exc(input logic [NUM_EXC-1:0] v);
    lowest_exc = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--)
      if (v[i]) lowest_exc = 5'(i);
  endfunction

  function automatic logic [4:0] lowest_irq(input logic [NUM_IRQ-1:0] v);
    lowest_irq = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (v[i]) lowest_irq = 5'(i);
  endfunction

  function automatic logic [31:0] exc_cause(input logic [4:0] idx);
    exc_cause = 32'(idx) + 32'd1;
  endfunction

  function automatic logic [31:0] irq_cause(input logic [4:0] idx);
    irq_cause = 32'h8000_0000 | (32'(IRQ_CAUSE_BASE) + 32'(idx));
  endfunction

  assign w_irq_act = r_pending & r_enable;
  assign w_exc_any = |exc_vec;
  assign w_irq_go  = global_ie & (|w_irq_act);
  assign w_exc_idx = lowest_exc(exc_vec);
  assign w_irq_idx = lowest_irq(w_irq_act);

`ifdef IRQ_TRAP_CTRL_EDGE_EN
  logic [NUM_IRQ-1:0] r_irq_prev;
  logic [NUM_IRQ-1:0] w_ack_clr;
  logic [4:0]         r_claim;

  // A fresh rising edge on the acknowledged channel outranks the clear.
  always_comb begin
    w_ack_clr = '0;
    if (r_state == REQ && trap_ack && r_is_irq)
      for (int i = 0; i < NUM_IRQ; i++)
        if (r_claim == 5'(i)) w_ack_clr[i] = 1'b1;
    w_pending_nxt = (r_pending & ~w_ack_clr) | (irq_in & ~r_irq_prev);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_prev <= '0;
      r_claim    <= '0;
    end else begin
      r_irq_prev <= irq_in;
      if (r_state == IDLE && !w_exc_any && w_irq_go)
        r_claim <= w_irq_idx;
    end
  end
`else
  always_comb w_pending_nxt = irq_in;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_cause_nxt  = r_cause;
    w_is_irq_nxt = r_is_irq;
    w_dfault_nxt = r_dfault;
    trap_req     = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_exc_any) begin
          w_state_nxt  = REQ;
          w_cause_nxt  = exc_cause(w_exc_idx);
          w_is_irq_nxt = 1'b0;
        end else if (w_irq_go) begin
          w_state_nxt  = REQ;
          w_cause_nxt  = irq_cause(w_irq_idx);
          w_is_irq_nxt = 1'b1;
        end
      end
      REQ: begin
        trap_req = 1'b1;
        // An exception pre-empts an interrupt that has not yet been taken.
        if (trap_ack) begin
          w_state_nxt = SERVICE;
        end else if (r_is_irq && w_exc_any) begin
          w_cause_nxt  = exc_cause(w_exc_idx);
          w_is_irq_nxt = 1'b0;
        end
      end
      SERVICE: begin
        busy = 1'b1;
        if (w_exc_any)   w_dfault_nxt = 1'b1;
        if (trap_return) w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cause   <= '0;
      r_is_irq  <= 1'b0;
      r_dfault  <= 1'b0;
      r_pending <= '0;
      r_enable  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cause   <= w_cause_nxt;
      r_is_irq  <= w_is_irq_nxt;
      r_dfault  <= w_dfault_nxt;
      r_pending <= w_pending_nxt;
      if (irq_en_we) r_enable <= irq_en_wdata;
    end
  end

  assign trap_cause   = r_cause;
  assign trap_is_irq  = r_is_irq;
  assign irq_pending  = r_pending;
  assign double_fault = r_dfault;

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Bench for irq_trap_ctrl: directed trap scenarios followed by random traffic against a behavioural model.
module tb_irq_trap_ctrl;
  localparam int NI   = 8;
  localparam int NE   = 4;
  localparam int BASE = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [NE-1:0] exc_vec;
  logic [NI-1:0] irq_in, irq_en_wdata;
  logic          irq_en_we, global_ie, trap_ack, trap_return;
  logic          trap_req, trap_is_irq, busy, double_fault;
  logic [31:0]   trap_cause;
  logic [NI-1:0] irq_pending;

  int total = 0;
  int bad   = 0;

  // Model: 0 = idle, 1 = trap presented, 2 = in service
  int            m_st, m_claim;
  logic [31:0]   m_cause;
  bit            m_irq, m_df, m_rst;
  logic [NI-1:0] m_pend, m_en, m_prev;

  always #5 clk = ~clk;

  irq_trap_ctrl #(.NUM_IRQ(NI), .NUM_EXC(NE), .IRQ_CAUSE_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .exc_vec(exc_vec), .irq_in(irq_in),
    .irq_en_wdata(irq_en_wdata), .irq_en_we(irq_en_we), .global_ie(global_ie),
    .trap_ack(trap_ack), .trap_return(trap_return), .trap_req(trap_req),
    .trap_cause(trap_cause), .trap_is_irq(trap_is_irq), .irq_pending(irq_pending),
    .busy(busy), .double_fault(double_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int lowest(input logic [31:0] v);
    for (int i = 0; i < 32; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    logic [NI-1:0] np;
    int e, q;
    m_rst = reset;
    if (reset) begin
      m_st = 0; m_cause = '0; m_irq = 0; m_df = 0; m_claim = 0;
      m_pend = '0; m_en = '0; m_prev = '0;
      return;
    end
    e = lowest(32'(exc_vec));
    q = lowest(32'(m_pend & m_en));
`ifdef IRQ_TRAP_CTRL_EDGE_EN
    np = m_pend;
    if (m_st == 1 && trap_ack && m_irq) np[m_claim] = 1'b0;
    np = np | (irq_in & ~m_prev);
`else
    np = irq_in;
`endif
    case (m_st)
      0: begin
        if (e >= 0) begin
          m_st = 1; m_cause = 32'(e + 1); m_irq = 0;
        end else if (global_ie && q >= 0) begin
          m_st = 1; m_cause = 32'h8000_0000 + 32'(BASE + q); m_irq = 1; m_claim = q;
        end
      end
      1: begin
        if (trap_ack) m_st = 2;
        else if (m_irq && e >= 0) begin
          m_cause = 32'(e + 1); m_irq = 0;
        end
      end
      default: begin
        if (e >= 0) m_df = 1;
        if (trap_return) m_st = 0;
      end
    endcase
    m_pend = np;
    m_prev = irq_in;
    if (irq_en_we) m_en = irq_en_wdata;
  endtask

  task automatic check_model();
    chk("m_trap_req", 32'(trap_req), 32'(m_st == 1));
    chk("m_busy", 32'(busy), 32'(m_st == 2));
    chk("m_pending", 32'(irq_pending), 32'(m_pend));
    chk("m_double_fault", 32'(double_fault), 32'(m_df));
    if (m_st != 0 || m_rst) begin
      chk("m_trap_cause", trap_cause, m_cause);
      chk("m_trap_is_irq", 32'(trap_is_irq), 32'(m_irq));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  initial begin
    reset = 1'b1; exc_vec = '0; irq_in = '0; irq_en_wdata = '0; irq_en_we = 1'b0;
    global_ie = 1'b0; trap_ack = 1'b0; trap_return = 1'b0;
    tick(); tick();
    chk("rst_trap_req", 32'(trap_req), 0);
    chk("rst_cause", trap_cause, 0);
    chk("rst_pending", 32'(irq_pending), 0);
    reset = 1'b0;

    // Exception from idle
    exc_vec = 4'b0110; tick();
    chk("exc_req", 32'(trap_req), 1);
    chk("exc_cause", trap_cause, 2);
    chk("exc_is_irq", 32'(trap_is_irq), 0);
    exc_vec = '0; trap_ack = 1'b1; tick();
    chk("exc_busy", 32'(busy), 1);
    trap_ack = 1'b0; trap_return = 1'b1; tick();
    chk("exc_ret_idle", 32'(busy), 0);
    trap_return = 1'b0;

    // Interrupt latency and priority
    irq_en_we = 1'b1; irq_en_wdata = 8'hFF; global_ie = 1'b1; irq_in = 8'b0010_0100; tick();
    chk("irq_not_yet", 32'(trap_req), 0);
    chk("irq_pend", 32'(irq_pending), 32'h24);
    irq_en_we = 1'b0; tick();
    chk("irq_req", 32'(trap_req), 1);
    chk("irq_cause", trap_cause, 32'h8000_0012);
    chk("irq_is_irq", 32'(trap_is_irq), 1);

    // Exception pre-empts a presented interrupt
    exc_vec = 4'b0001; tick();
    chk("preempt_cause", trap_cause, 1);
    chk("preempt_is_irq", 32'(trap_is_irq), 0);

    // Exception during service, then pending work after return
    exc_vec = '0; trap_ack = 1'b1; tick();
    chk("svc_busy", 32'(busy), 1);
    trap_ack = 1'b0; exc_vec = 4'b0001; tick();
    chk("svc_no_req", 32'(trap_req), 0);
    chk("svc_dfault", 32'(double_fault), 1);
    exc_vec = '0; trap_return = 1'b1; tick();
    chk("svc_ret_busy", 32'(busy), 0);
    trap_return = 1'b0; tick();
    chk("after_ret_req", 32'(trap_req), 1);
    chk("after_ret_cause", trap_cause, 32'h8000_0012);

    // Global enable gating
    irq_in = '0; reset = 1'b1; tick();
    reset = 1'b0; irq_en_we = 1'b1; irq_en_wdata = 8'hFF; global_ie = 1'b0; irq_in = 8'h08; tick();
    irq_en_we = 1'b0; tick(); tick();
    chk("gie_off_req", 32'(trap_req), 0);
    chk("gie_off_pend", 32'(irq_pending), 32'h08);
    global_ie = 1'b1; tick();
    chk("gie_on_req", 32'(trap_req), 1);
    chk("gie_on_cause", trap_cause, 32'h8000_0013);

    // Reset in service
    trap_ack = 1'b1; tick();
    trap_ack = 1'b0;
    chk("rs_busy", 32'(busy), 1);
    exc_vec = 4'b0001; tick();
    chk("rs_dfault", 32'(double_fault), 1);
    exc_vec = '0; reset = 1'b1; tick();
    chk("rs_busy0", 32'(busy), 0);
    chk("rs_pend0", 32'(irq_pending), 0);
    chk("rs_dfault0", 32'(double_fault), 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rs_enable0_noreq", 32'(trap_req), 0);
    end
    chk("rs_pend_again", 32'(irq_pending), 32'h08);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      reset       = ($urandom_range(0, 199) == 0);
      exc_vec     = ($urandom_range(0, 99) < 8) ? NE'($urandom) : '0;
      for (int b = 0; b < NI; b++)
        if ($urandom_range(0, 99) < 15) irq_in[b] = ~irq_in[b];
      irq_en_we    = ($urandom_range(0, 99) < 5);
      irq_en_wdata = NI'($urandom);
      global_ie    = ($urandom_range(0, 99) < 90);
      trap_ack     = ($urandom_range(0, 99) < 40);
      trap_return  = ($urandom_range(0, 99) < 30);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
